// File: rtl/npc_mem_pkg.sv
// Shared types and constants for the NPC memory arbiter.
// State encoding, owner encoding and default bus widths.
package npc_mem_pkg;

  localparam int NPC_ADDR_W = 24;
  localparam int NPC_DATA_W = 32;

  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module mem_arb_pick
  import npc_mem_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant,
  output logic       owner
);

  logic conflict_owner;

`ifdef MEM_ARB_RR_EN
  // On a tie the side that did not win last time goes first.
  assign conflict_owner = ~last_grant;
`else
  assign conflict_owner = OWN_LSU;
`endif

  always_comb begin
    owner = OWN_IFU;
    unique case (1'b1)
      (ifu_valid && lsu_valid):  owner = conflict_owner;
      (lsu_valid && !ifu_valid): owner = OWN_LSU;
      default:                   owner = OWN_IFU;
    endcase
    grant          = 2'b00;
    grant[OWN_IFU] = ifu_valid && (owner == OWN_IFU);
    grant[OWN_LSU] = lsu_valid && (owner == OWN_LSU);
  end

endmodule

// File: rtl/mem_arb.sv
// Two-requester memory arbiter/sequencer (IFU + LSU onto one port).
// Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arb
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W = NPC_ADDR_W,
  parameter int DATA_W = NPC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [3:0]        lsu_req_mask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]        state;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        mask_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        grant;
  logic              pick_owner;
  logic              accept;

`ifdef MEM_ARB_RR_EN
  logic last_grant;
`endif

  mem_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .grant      (grant),
    .owner      (pick_owner)
  );

  // Ready is combinational from the pick, suppressed while in reset.
  assign accept        = (state == S_IDLE) && !rst && (|grant);
  assign ifu_req_ready = accept && grant[OWN_IFU];
  assign lsu_req_ready = accept && grant[OWN_LSU];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      mask_q  <= 4'b0000;
      rdata_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            owner_q <= pick_owner;
            state   <= S_REQ;
            if (pick_owner == OWN_LSU) begin
              addr_q  <= lsu_req_addr;
              wen_q   <= lsu_req_wen;
              wdata_q <= lsu_req_wdata;
              mask_q  <= lsu_req_mask;
            end else begin
              addr_q  <= ifu_req_addr;
              wen_q   <= 1'b0;
              wdata_q <= '0;
              mask_q  <= MASK_WORD;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            rdata_q <= wen_q ? '0 : mem_resp_data;
            state   <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_IFU;
    end else if (accept) begin
      last_grant <= pick_owner;
    end
  end
`endif

  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_mask  = mask_q;

  assign ifu_resp_valid = (state == S_RESP) && (owner_q == OWN_IFU);
  assign lsu_resp_valid = (state == S_RESP) && (owner_q == OWN_LSU);
  assign ifu_resp_data  = ifu_resp_valid ? rdata_q : '0;
  assign lsu_resp_data  = lsu_resp_valid ? rdata_q : '0;

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Randomized bench for mem_arb against a transaction-timeline model.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [23:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [23:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_mask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [23:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        busy;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_mask(lsu_req_mask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  typedef struct {
    logic [23:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        own;
  } txn_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Which side wins given the two valids and the last winner (1 = LSU).
  function automatic bit pick_lsu(bit iv, bit lv, bit lg);
    if (iv && lv) begin
`ifdef MEM_ARB_RR_EN
      return ~lg;
`else
      return 1'b1;
`endif
    end
    return lv;
  endfunction

  logic [31:0] memarr [16];
  int   cyc;
  bit   have, last_g;
  int   acc, rdy, rsp;
  txn_t cur;
  logic [31:0] exp_rdata, mem_rd;
  bit   e_req, e_wait, e_resp, e_busy, e_ir, e_lr, win;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                        logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) memarr[i] = $urandom;
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 24'h10;
    lsu_req_valid = 1'b1; lsu_req_addr = 24'h4;
    lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_mask = 4'hF;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_iready", {31'd0, ifu_req_ready}, 32'd0);
    chk("rst_lready", {31'd0, lsu_req_ready}, 32'd0);
    chk("rst_mvalid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_iresp", {31'd0, ifu_resp_valid}, 32'd0);
    chk("rst_lresp", {31'd0, lsu_resp_valid}, 32'd0);
    chk("rst_maddr", {8'd0, mem_req_addr}, 32'd0);
    chk("rst_mmask", {28'd0, mem_req_mask}, 32'd0);
    chk("rst_idata", ifu_resp_data, 32'd0);
    chk("rst_ldata", lsu_resp_data, 32'd0);

    have = 0; last_g = 0; acc = -1; rdy = -1; rsp = -1;
    rst = 1'b0;
    mem_rd = '0; exp_rdata = '0;
    cyc = 0;

    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      e_req  = have && (rdy < 0 || cyc <= rdy);
      e_wait = have && rdy >= 0 && cyc > rdy && rsp < 0;
      e_resp = have && rsp >= 0 && cyc == rsp + 1;
      e_busy = e_req || e_wait || e_resp;
      win    = pick_lsu(ifu_req_valid, lsu_req_valid, last_g);
      e_ir   = !rst && !e_busy && ifu_req_valid && !win;
      e_lr   = !rst && !e_busy && lsu_req_valid && win;

      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("ifu_ready", {31'd0, ifu_req_ready}, {31'd0, e_ir});
      chk("lsu_ready", {31'd0, lsu_req_ready}, {31'd0, e_lr});
      chk("mem_valid", {31'd0, mem_req_valid}, {31'd0, e_req});
      chk("ifu_resp", {31'd0, ifu_resp_valid},
          {31'd0, e_resp && cur.own == 1'b0});
      chk("lsu_resp", {31'd0, lsu_resp_valid},
          {31'd0, e_resp && cur.own == 1'b1});
      if (e_req) begin
        chk("mem_addr", {8'd0, mem_req_addr}, {8'd0, cur.addr});
        chk("mem_wen", {31'd0, mem_req_wen}, {31'd0, cur.wen});
        chk("mem_mask", {28'd0, mem_req_mask}, {28'd0, cur.mask});
        if (cur.own) chk("mem_wdata", mem_req_wdata, cur.wdata);
      end
      if (e_resp && !cur.own) chk("ifu_data", ifu_resp_data, exp_rdata);
      if (e_resp && cur.own)  chk("lsu_data", lsu_resp_data, exp_rdata);

      @(posedge clk);
      if (rst) begin
        have = 0; last_g = 0;
      end else begin
        if (e_resp) have = 0;
        if (e_wait && mem_resp_valid) rsp = cyc;
        if (e_req && mem_req_ready) begin
          rdy = cyc;
          exp_rdata = cur.wen ? 32'd0 : memarr[cur.addr[3:0]];
          mem_rd = cur.wen ? $urandom : memarr[cur.addr[3:0]];
          if (cur.wen)
            memarr[cur.addr[3:0]] =
              merge(memarr[cur.addr[3:0]], cur.wdata, cur.mask);
        end
        if (e_ir || e_lr) begin
          have = 1; acc = cyc; rdy = -1; rsp = -1;
          if (e_lr) begin
            cur.addr = lsu_req_addr; cur.wen = lsu_req_wen;
            cur.wdata = lsu_req_wdata; cur.mask = lsu_req_mask;
            cur.own = 1'b1; last_g = 1;
          end else begin
            cur.addr = ifu_req_addr; cur.wen = 1'b0;
            cur.wdata = '0; cur.mask = 4'hF;
            cur.own = 1'b0; last_g = 0;
          end
        end
      end
      cyc++;

      #1;
      if (e_ir) ifu_req_valid = 1'b0;
      if (e_lr) lsu_req_valid = 1'b0;
      rst = ($urandom_range(0, 149) == 0);
      if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
        ifu_req_valid = 1'b1;
        ifu_req_addr = 24'($urandom_range(0, 15));
      end
      if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
        lsu_req_valid = 1'b1;
        lsu_req_addr = 24'($urandom_range(0, 15));
        lsu_req_wen = 1'($urandom_range(0, 1));
        lsu_req_wdata = $urandom;
        lsu_req_mask = 4'($urandom_range(0, 15));
      end
      mem_req_ready  = ($urandom_range(0, 2) == 0);
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_resp_data  = (have && rdy >= 0 && rsp < 0) ? mem_rd : $urandom;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
